// File: rtl/morse_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_frame_sequencer
//  Description : Collects keyed dot/dash elements into fixed-width character
//                codes and packs NUM_CHARS codes into one frame. It then
//                strobes the Morse translator for one cycle, waits out the
//                translator latency, and offers the result downstream through
//                a frame_valid / frame_ack handshake.
//
//  Ports
//    clk           in   system clock, rising edge
//    rst_n         in   synchronous active-low reset
//    elem_valid    in   one-cycle strobe, one element keyed
//    elem_dash     in   element type for elem_valid (1 = dash, 0 = dot)
//    char_end      in   one-cycle strobe, current character complete
//    flush         in   one-cycle strobe, send a partial frame now
//    in_ready      out  inputs accepted (high only while collecting)
//    sequences     out  frame to translator, slot 0 in the MSBs
//    storage_sent  out  one-cycle translate strobe
//    frame_valid   out  translator output valid, held until frame_ack
//    frame_ack     in   downstream consumed the frame
//    char_count    out  completed characters in the current frame
//    drop_err      out  sticky, a strobe arrived while in_ready was low
//
//  Revision    : 1.0  initial release
// ============================================================================
module morse_frame_sequencer #(
    parameter int ELEM_W    = 2,
    parameter int MAX_ELEMS = 5,
    parameter int NUM_CHARS = 3,
    parameter int XLAT_LAT  = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   elem_valid,
    input  logic                                   elem_dash,
    input  logic                                   char_end,
    input  logic                                   flush,
    output logic                                   in_ready,
    output logic [ELEM_W*MAX_ELEMS*NUM_CHARS-1:0]  sequences,
    output logic                                   storage_sent,
    output logic                                   frame_valid,
    input  logic                                   frame_ack,
    output logic [$clog2(NUM_CHARS+1)-1:0]         char_count,
    output logic                                   drop_err
);

    localparam int c_CODE_W  = ELEM_W * MAX_ELEMS;
    localparam int c_FRAME_W = c_CODE_W * NUM_CHARS;
    localparam int c_CNT_W   = $clog2(MAX_ELEMS + 1);
    localparam int c_CC_W    = $clog2(NUM_CHARS + 1);
    localparam int c_WAIT_W  = (XLAT_LAT > 1) ? $clog2(XLAT_LAT) : 1;

    localparam logic [ELEM_W-1:0]    c_DOT        = ELEM_W'(0);
    localparam logic [ELEM_W-1:0]    c_DASH       = ELEM_W'(1);
    localparam logic [c_CODE_W-1:0]  c_EMPTY_CODE = '1;
    localparam logic [c_FRAME_W-1:0] c_EMPTY_FRM  = '1;

    localparam logic [1:0] c_ST_COLLECT = 2'd0;
    localparam logic [1:0] c_ST_SEND    = 2'd1;
    localparam logic [1:0] c_ST_WAIT    = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [c_CODE_W-1:0]  r_builder;
    logic [c_CNT_W-1:0]   r_elem_cnt;
    logic                 r_ovf;
    logic [c_FRAME_W-1:0] r_seq;
    logic [c_CC_W-1:0]    r_cc;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic                 r_storage_sent;
    logic                 r_frame_valid;
    logic                 r_in_ready;
    logic                 r_drop_err;

    // Next-state values
    logic [1:0]           w_state;
    logic [c_CODE_W-1:0]  w_builder;
    logic [c_CNT_W-1:0]   w_elem_cnt;
    logic                 w_ovf;
    logic [c_FRAME_W-1:0] w_seq;
    logic [c_CC_W-1:0]    w_cc;
    logic [c_WAIT_W-1:0]  w_wait_cnt;
    logic                 w_drop;
    logic [ELEM_W-1:0]    w_elem_code;

    assign w_elem_code = elem_dash ? c_DASH : c_DOT;

    // ------------------------------------------------------------------------
    // Next-state logic. Within COLLECT the same-cycle events are evaluated in
    // sequence (append, then close, then flush), each stage working on the
    // result of the previous one, so a close includes that cycle's element.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state    = r_state;
        w_builder  = r_builder;
        w_elem_cnt = r_elem_cnt;
        w_ovf      = r_ovf;
        w_seq      = r_seq;
        w_cc       = r_cc;
        w_wait_cnt = r_wait_cnt;
        w_drop     = r_drop_err |
                     ((r_state != c_ST_COLLECT) && (elem_valid || char_end || flush));

        case (r_state)
            c_ST_COLLECT: begin
                // Append: next free slot counted from the MSB end.
                if (elem_valid) begin
                    if (r_elem_cnt < c_CNT_W'(MAX_ELEMS)) begin
                        for (int i = 0; i < MAX_ELEMS; i++) begin
                            if (r_elem_cnt == c_CNT_W'(i)) begin
                                w_builder[c_CODE_W-1-ELEM_W*i -: ELEM_W] = w_elem_code;
                            end
                        end
                        w_elem_cnt = r_elem_cnt + c_CNT_W'(1);
                    end else begin
                        w_ovf = 1'b1;
                    end
                end

                // Close: an overflowed character is stored as the null code.
                if (char_end && ((w_elem_cnt != '0) || w_ovf)) begin
                    for (int k = 0; k < NUM_CHARS; k++) begin
                        if (r_cc == c_CC_W'(k)) begin
                            w_seq[c_FRAME_W-1-c_CODE_W*k -: c_CODE_W] =
                                w_ovf ? c_EMPTY_CODE : w_builder;
                        end
                    end
                    w_cc       = r_cc + c_CC_W'(1);
                    w_builder  = c_EMPTY_CODE;
                    w_elem_cnt = '0;
                    w_ovf      = 1'b0;
                end

                // Send on a full frame or a flush with something stored; any
                // unclosed character is discarded at that point.
                if ((w_cc == c_CC_W'(NUM_CHARS)) || (flush && (w_cc != '0))) begin
                    w_state    = c_ST_SEND;
                    w_builder  = c_EMPTY_CODE;
                    w_elem_cnt = '0;
                    w_ovf      = 1'b0;
                end
            end

            c_ST_SEND: begin
                w_state    = c_ST_WAIT;
                w_wait_cnt = '0;
            end

            c_ST_WAIT: begin
                if (r_wait_cnt == c_WAIT_W'(XLAT_LAT - 1)) begin
                    w_state = c_ST_DONE;
                end else begin
                    w_wait_cnt = r_wait_cnt + c_WAIT_W'(1);
                end
            end

            c_ST_DONE: begin
                if (frame_ack) begin
                    w_state = c_ST_COLLECT;
                    w_seq   = c_EMPTY_FRM;
                    w_cc    = '0;
                end
            end

            default: begin
                w_state = c_ST_COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers. The handshake outputs are decoded from the next state so
    // they are registered and line up with the state they describe.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= c_ST_COLLECT;
            r_builder      <= c_EMPTY_CODE;
            r_elem_cnt     <= '0;
            r_ovf          <= 1'b0;
            r_seq          <= c_EMPTY_FRM;
            r_cc           <= '0;
            r_wait_cnt     <= '0;
            r_storage_sent <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_in_ready     <= 1'b1;
            r_drop_err     <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_builder      <= w_builder;
            r_elem_cnt     <= w_elem_cnt;
            r_ovf          <= w_ovf;
            r_seq          <= w_seq;
            r_cc           <= w_cc;
            r_wait_cnt     <= w_wait_cnt;
            r_storage_sent <= (w_state == c_ST_SEND);
            r_frame_valid  <= (w_state == c_ST_DONE);
            r_in_ready     <= (w_state == c_ST_COLLECT);
            r_drop_err     <= w_drop;
        end
    end

    assign in_ready     = r_in_ready;
    assign sequences    = r_seq;
    assign storage_sent = r_storage_sent;
    assign frame_valid  = r_frame_valid;
    assign char_count   = r_cc;
    assign drop_err     = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_morse_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_frame_sequencer
//  Description : Self-checking bench for morse_frame_sequencer. Expected
//                frames are queued when the closing stimulus is driven and
//                compared whenever the sequencer strobes storage_sent.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_morse_frame_sequencer;

    localparam logic [9:0] c_S    = 10'b0000001111;
    localparam logic [9:0] c_O    = 10'b0101011111;
    localparam logic [9:0] c_E1   = 10'b0011111111;  // single dot
    localparam logic [9:0] c_NUL  = 10'h3FF;
    localparam logic [9:0] c_DD   = 10'b0000011111;  // dot dot dash
    localparam logic [9:0] c_D5   = 10'b0101010101;  // five dashes
    localparam logic [29:0] c_ONES = 30'h3FFFFFFF;

    typedef struct packed {
        logic [29:0] seq;
        logic [1:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        elem_valid;
    logic        elem_dash;
    logic        char_end;
    logic        flush;
    logic        in_ready;
    logic [29:0] sequences;
    logic        storage_sent;
    logic        frame_valid;
    logic        frame_ack;
    logic [1:0]  char_count;
    logic        drop_err;

    int   n_vec    = 0;
    int   n_miscmp = 0;
    exp_t sb_q[$];

    morse_frame_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .elem_valid   (elem_valid),
        .elem_dash    (elem_dash),
        .char_end     (char_end),
        .flush        (flush),
        .in_ready     (in_ready),
        .sequences    (sequences),
        .storage_sent (storage_sent),
        .frame_valid  (frame_valid),
        .frame_ack    (frame_ack),
        .char_count   (char_count),
        .drop_err     (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every translate strobe must match the oldest queued frame.
    always @(negedge clk) begin
        if (storage_sent) begin
            if (sb_q.size() == 0) begin
                chk("spurious_send", 32'(storage_sent), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_sequences", 32'(sequences), 32'(e.seq));
                chk("sb_char_count", 32'(char_count), 32'(e.cnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic d);
        elem_valid = 1'b1;
        elem_dash  = d;
        tick();
        elem_valid = 1'b0;
        elem_dash  = 1'b0;
    endtask

    task automatic cend();
        char_end = 1'b1;
        tick();
        char_end = 1'b0;
    endtask

    task automatic fl();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic push(input logic [29:0] s, input logic [1:0] c);
        exp_t e;
        e.seq = s;
        e.cnt = c;
        sb_q.push_back(e);
    endtask

    task automatic wait_fv();
        for (int i = 0; i < 20; i++) begin
            if (frame_valid) break;
            tick();
        end
        chk("frame_valid_timeout", 32'(frame_valid), 32'd1);
    endtask

    task automatic ack_and_check();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ack_in_ready", 32'(in_ready), 32'd1);
        chk("ack_char_count", 32'(char_count), 32'd0);
        chk("ack_sequences", 32'(sequences), 32'(c_ONES));
        chk("ack_frame_valid", 32'(frame_valid), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_sequences"}, 32'(sequences), 32'(c_ONES));
        chk({tag, "_char_count"}, 32'(char_count), 32'd0);
        chk({tag, "_storage_sent"}, 32'(storage_sent), 32'd0);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        chk({tag, "_drop_err"}, 32'(drop_err), 32'd0);
    endtask

    task automatic quiet_after_reset(input string tag);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk({tag, "_no_fv"}, 32'(frame_valid), 32'd0);
            chk({tag, "_no_send"}, 32'(storage_sent), 32'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        elem_valid = 1'b0;
        elem_dash  = 1'b0;
        char_end   = 1'b0;
        flush      = 1'b0;
        frame_ack  = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // SOS with exact latency checks
        for (int i = 0; i < 3; i++) key(1'b0);
        cend();
        chk("sos_cc1", 32'(char_count), 32'd1);
        for (int i = 0; i < 3; i++) key(1'b1);
        cend();
        for (int i = 0; i < 3; i++) key(1'b0);
        push({c_S, c_O, c_S}, 2'd3);
        cend();
        chk("sos_send_e1", 32'(storage_sent), 32'd1);
        chk("sos_seq", 32'(sequences), 32'({c_S, c_O, c_S}));
        chk("sos_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("sos_send_once", 32'(storage_sent), 32'd0);
        chk("sos_fv_e2", 32'(frame_valid), 32'd0);
        tick();
        chk("sos_fv_e3", 32'(frame_valid), 32'd1);
        ack_and_check();

        // single O then flush
        for (int i = 0; i < 3; i++) key(1'b1);
        cend();
        push({c_O, c_NUL, c_NUL}, 2'd1);
        fl();
        wait_fv();
        ack_and_check();

        // overflow and same-cycle element + close, then hold in DONE
        for (int i = 0; i < 6; i++) key(1'b0);
        cend();
        chk("ovf_cc", 32'(char_count), 32'd1);
        key(1'b0);
        key(1'b0);
        elem_valid = 1'b1;
        elem_dash  = 1'b1;
        char_end   = 1'b1;
        tick();
        elem_valid = 1'b0;
        elem_dash  = 1'b0;
        char_end   = 1'b0;
        chk("same_cycle_cc", 32'(char_count), 32'd2);
        push({c_NUL, c_DD, c_NUL}, 2'd2);
        fl();
        wait_fv();
        for (int i = 0; i < 10; i++) begin
            elem_valid = 1'b1;
            tick();
            elem_valid = 1'b0;
            chk("hold_fv", 32'(frame_valid), 32'd1);
            chk("hold_seq", 32'(sequences), 32'({c_NUL, c_DD, c_NUL}));
        end
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_drop_err", 32'(drop_err), 32'd1);
        ack_and_check();

        // flush / char_end with nothing to act on
        fl();
        cend();
        chk("idle_cc", 32'(char_count), 32'd0);
        chk("idle_seq", 32'(sequences), 32'(c_ONES));
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        chk("idle_no_fv", 32'(frame_valid), 32'd0);

        // exactly five elements, partial character discarded by flush
        for (int i = 0; i < 5; i++) key(1'b1);
        cend();
        key(1'b0);
        cend();
        key(1'b0);
        push({c_D5, c_E1, c_NUL}, 2'd2);
        fl();
        wait_fv();
        ack_and_check();
        cend();
        chk("partial_discarded_cc", 32'(char_count), 32'd0);

        // reset during WAIT
        for (int i = 0; i < 2; i++) begin
            key(1'b0);
            cend();
        end
        key(1'b0);
        push({c_E1, c_E1, c_E1}, 2'd3);
        cend();
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_vals("rst_wait");
        rst_n = 1'b1;
        quiet_after_reset("rst_wait");

        // reset during DONE
        for (int i = 0; i < 2; i++) begin
            key(1'b1);
            cend();
        end
        key(1'b0);
        push({10'b0111111111, 10'b0111111111, c_E1}, 2'd3);
        cend();
        wait_fv();
        rst_n = 1'b0;
        tick();
        check_reset_vals("rst_done");
        rst_n = 1'b1;
        quiet_after_reset("rst_done");

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_frame_sequencer.md
# morse_frame_sequencer

Controller that sequences the Morse sequence translator. It assembles keyed dot/dash elements into 10-bit character codes and packs three codes into a 30-bit frame. It then drives `storage_sent` for exactly one cycle, waits out the translator latency, and presents a frame-valid/acknowledge handshake to the downstream display or serial stage. It sits between the key debouncer/element classifier and the translator.

## Interface
- `ELEM_W`, 2: bits per element slot; dot = `00`, dash = `01`, empty = `11`.
- `MAX_ELEMS`, 5: element slots per character code (code width = ELEM_W*MAX_ELEMS = 10).
- `NUM_CHARS`, 3: character codes per frame (frame width 30).
- `XLAT_LAT`, 1: cycles from the `storage_sent` edge until translator output is valid.

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `elem_valid`  in  1  one-cycle strobe: one element keyed.
- `elem_dash`  in  1  qualifies `elem_valid`: 1 = dash, 0 = dot.
- `char_end`  in  1  one-cycle strobe: current character complete.
- `flush`  in  1  one-cycle strobe: send a partial frame now.
- `in_ready`  out  1  high when elements, `char_end` and `flush` are accepted.
- `sequences`  out  30  frame to translator; slot 0 = [29:20], slot 1 = [19:10], slot 2 = [9:0].
- `storage_sent`  out  1  one-cycle translate strobe to translator.
- `frame_valid`  out  1  translator output valid; held until acknowledged.
- `frame_ack`  in  1  downstream consumed frame.
- `char_count`  out  2  completed characters in current frame (0..3).
- `drop_err`  out  1  sticky: an input strobe arrived while `in_ready` = 0.

## Operation
- FSM states: COLLECT, SEND, WAIT, DONE. Reset state is COLLECT.
- Reset values: `sequences` = all ones (30'h3FFFFFFF), builder = all ones, element count 0, overflow flag 0, `char_count` 0, `storage_sent` 0, `frame_valid` 0, `drop_err` 0, `in_ready` 1.
- COLLECT, `elem_valid`:
  - If element count < 5, write the element code into the next slot from the MSB, so the first element lands at builder[9:8], then increment the count.
  - If the count is already 5, set the overflow flag.
- COLLECT, `char_end`:
  - If element count = 0 and overflow = 0, ignore it.
  - Otherwise store the builder into slot `char_count`, or store 10'h3FF if overflow = 1. Increment `char_count`, reset the builder to ones, and clear the count and overflow.
- Unused trailing element slots remain `11`.
  - S = `0000001111`.
  - O = `0101011111`.
- Same-cycle events resolve in this order: element append, then `char_end` close, then `flush` evaluation. The closed character includes that cycle's element.
- Move COLLECT -> SEND when either condition holds:
  - the third character closes, or
  - `flush` arrives with `char_count` > 0 after any same-cycle close.
- `flush` with nothing stored is ignored. A partially built (unclosed) character at flush is discarded. Unfilled slots stay 10'h3FF, which the translator renders as null.
- SEND: `storage_sent` = 1 for exactly one cycle, with `sequences` stable; then go to WAIT.
- WAIT: stay XLAT_LAT cycles, then go to DONE.
- DONE: `frame_valid` = 1 until a cycle with `frame_ack` = 1. In that cycle go to COLLECT, and on the same edge set `sequences` to all ones and `char_count` to 0.
- `in_ready` = 1 only in COLLECT. Any `elem_valid`/`char_end`/`flush` while `in_ready` = 0 is dropped and sets `drop_err`. Only reset clears `drop_err`.
- `frame_ack` outside DONE is ignored.
- `rst_n` low in any state returns to the reset values on that edge. No `storage_sent` may be emitted on the reset edge.

## Timing
- Inputs are sampled on the rising edge. All outputs are registered.
- Third `char_end` sampled at edge E:
  - `storage_sent` = 1 in cycle E+1 only.
  - `frame_valid` rises in cycle E+1+XLAT_LAT+1, which is E+3 with defaults.
- `sequences` is constant from the edge that enters SEND until the `frame_ack` edge.
- Minimum frame turnaround with immediate ack is 4 cycles from the last close to `in_ready` = 1.
- Back-to-back `elem_valid` at one per cycle is supported with no throughput loss in COLLECT.

## Test plan
- Reset, then key dot x3 + `char_end`, dash x3 + `char_end`, dot x3 + `char_end` -> `sequences` = 0000001111_0101011111_0000001111. `storage_sent` one cycle later, `frame_valid` two cycles after that, translator output = 24'h534F53 ("SOS").
- Key dash x3 + `char_end`, then `flush` -> slot 0 = `0101011111`, slots 1–2 = 10'h3FF, `char_count` = 1 at send, translated output 24'h4F0000.
- Key 6 dots + `char_end` -> slot 0 = 10'h3FF, `char_count` = 1. Also drive `elem_valid` and `char_end` in the same cycle -> the element is included in the stored code.
- Hold `frame_ack` = 0 for 10 cycles in DONE while pulsing `elem_valid` -> `frame_valid` stays high, `sequences` unchanged, `drop_err` = 1. Then `frame_ack` -> next cycle `in_ready` = 1, `char_count` = 0, `sequences` = all ones.
- Pulse `flush` with no characters and `char_end` with no elements -> no state change, `storage_sent` never asserts.
- Drop `rst_n` during WAIT and during DONE -> next cycle all outputs are at reset values, and no `storage_sent` or `frame_valid` pulse follows.
